// File: rtl/interval_timer.sv
// Programmable down-counting interval timer with one-shot/periodic modes, sticky irq and overrun.
// Optional tick prescaler compiled in with `define INTERVAL_TIMER_PRESCALE_EN.
module interval_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tick,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  mode,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expire,
  output logic                  irq,
  input  logic                  irq_ack,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] rld;
  logic             mode_l;
  logic             etick;
  logic             expiry;

`ifdef INTERVAL_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcnt;
  logic [PRESCALE_W-1:0] pre_l;

  // A count step happens only on the tick that completes a prescale period.
  assign etick = (state == RUN) && tick && (pcnt == pre_l);
`else
  logic unused_prescale;

  assign unused_prescale = ^prescale;
  assign etick           = (state == RUN) && tick;
`endif

  // stop in the same cycle masks the expiry entirely
  assign expiry     = etick && !stop && (count == ONE);
  assign busy       = (state == RUN);
  assign load_ready = (state != RUN);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      rld     <= '0;
      count   <= '0;
      mode_l  <= 1'b0;
      expire  <= 1'b0;
      irq     <= 1'b0;
      overrun <= 1'b0;
`ifdef INTERVAL_TIMER_PRESCALE_EN
      pcnt    <= '0;
      pre_l   <= '0;
`endif
    end else begin
      expire <= expiry;

      if (expiry)
        irq <= 1'b1;
      else if (irq_ack)
        irq <= 1'b0;

      if (expiry && irq && !irq_ack)
        overrun <= 1'b1;
      else if (irq_ack)
        overrun <= 1'b0;

`ifdef INTERVAL_TIMER_PRESCALE_EN
      if (state == RUN && tick)
        pcnt <= (pcnt == pre_l) ? '0 : pcnt + PRESCALE_W'(1);
`endif

      case (state)
        IDLE, DONE: begin
          if (load_valid)
            rld <= load_value;
          // The start uses the reload value held before any same-cycle load.
          if (start && !stop && (rld != '0)) begin
            count  <= rld;
            mode_l <= mode;
            state  <= RUN;
`ifdef INTERVAL_TIMER_PRESCALE_EN
            pcnt   <= '0;
            pre_l  <= prescale;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            count <= '0;
            state <= IDLE;
          end else if (etick) begin
            if (count == ONE) begin
              if (mode_l) begin
                count <= rld;
              end else begin
                count <= '0;
                state <= DONE;
              end
            end else begin
              count <= count - ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: scoreboard of expected expiry tick numbers plus inline checks.
module tb_interval_timer;

  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  logic                  clk = 1'b0;
  logic                  arst_n = 1'b0;
  logic                  tick = 1'b0;
  logic                  load_valid = 1'b0;
  logic                  load_ready;
  logic [WIDTH-1:0]      load_value = '0;
  logic                  mode = 1'b0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  expire;
  logic                  irq;
  logic                  irq_ack = 1'b0;
  logic                  overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  int exp_q[$];

  interval_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk), .arst_n(arst_n), .tick(tick), .load_valid(load_valid),
    .load_ready(load_ready), .load_value(load_value), .mode(mode),
    .start(start), .stop(stop), .prescale(prescale), .count(count),
    .busy(busy), .expire(expire), .irq(irq), .irq_ack(irq_ack),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are stable 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic do_start(input logic m, input logic [PRESCALE_W-1:0] p);
    mode     = m;
    prescale = p;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
  endtask

  // one tick every 4 clk; expire compared against the scoreboard each cycle
  task automatic run_ticks(input int n);
    logic exp_e;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      tick_no++;
      exp_e = (exp_q.size() > 0) && (exp_q[0] == tick_no);
      n_checks++;
      if (expire !== exp_e) begin
        n_fail++;
        $display("[TB] FAIL expire@tick%0d: got %b expected %b", tick_no, expire, exp_e);
      end
      if (exp_e) void'(exp_q.pop_front());
      for (int j = 0; j < 3; j++) begin
        cyc();
        n_checks++;
        if (expire !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL expire_idle@tick%0d: got %b expected 0", tick_no, expire);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({count, busy, expire, irq, overrun, load_ready} !== {16'h0, 5'b00001}) begin
      n_fail++;
      $display("[TB] FAIL reset: got cnt=%0h b=%b e=%b i=%b o=%b lr=%b expected 0 0 0 0 0 1",
               count, busy, expire, irq, overrun, load_ready);
    end
    cyc();
    arst_n = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    tick_no = 0;
    exp_q.push_back(5);
    do_load(16'd5);
    do_start(1'b0, 8'd0);
    n_checks++;
    if ({busy, count} !== {1'b1, 16'd5}) begin
      n_fail++;
      $display("[TB] FAIL oneshot_start: got busy=%b count=%0d expected 1 5", busy, count);
    end
    run_ticks(6);
    n_checks++;
    if ({irq, busy, count, load_ready} !== {1'b1, 1'b0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL oneshot_done: got irq=%b busy=%b count=%0d lr=%b expected 1 0 0 1",
               irq, busy, count, load_ready);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL oneshot_sb: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_periodic_overrun();
    do_ack();
    tick_no = 0;
    exp_q.push_back(3);
    exp_q.push_back(6);
    exp_q.push_back(9);
    do_load(16'd3);
    do_start(1'b1, 8'd0);
    run_ticks(3);
    n_checks++;
    if ({irq, overrun} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL periodic_t3: got irq=%b ovr=%b expected 1 0", irq, overrun);
    end
    run_ticks(3);
    n_checks++;
    if ({irq, overrun, busy} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL periodic_t6: got irq=%b ovr=%b busy=%b expected 1 1 1", irq, overrun, busy);
    end
    run_ticks(4);
    n_checks++;
    if (count !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL periodic_t10: got count=%0d expected 2", count);
    end
    do_ack();
    n_checks++;
    if ({irq, overrun} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL periodic_ack: got irq=%b ovr=%b expected 0 0", irq, overrun);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL periodic_sb: got %0d pending expected 0", exp_q.size());
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_stop_at_expiry();
    tick_no = 0;
    do_load(16'd2);
    do_start(1'b0, 8'd0);
    run_ticks(1);
    tick = 1'b1;
    stop = 1'b1;
    cyc();
    tick = 1'b0;
    stop = 1'b0;
    n_checks++;
    if ({expire, irq, busy, count} !== {3'b000, 16'd0}) begin
      n_fail++;
      $display("[TB] FAIL stop_expiry: got e=%b irq=%b busy=%b count=%0d expected 0 0 0 0",
               expire, irq, busy, count);
    end
    cyc();
    n_checks++;
    if (expire !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stop_expiry_late: got %b expected 0", expire);
    end
  endtask

  task automatic test_load_in_run();
    do_load(16'd4);
    do_start(1'b0, 8'd0);
    n_checks++;
    if (load_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_ready_run: got %b expected 0", load_ready);
    end
    do_load(16'd9);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    do_start(1'b0, 8'd0);
    n_checks++;
    if (count !== 16'd4) begin
      n_fail++;
      $display("[TB] FAIL rld_kept: got count=%0d expected 4", count);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    do_load(16'd0);
    do_start(1'b0, 8'd0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_rld0: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_ack_vs_expiry();
    do_load(16'd1);
    do_start(1'b0, 8'd0);
    tick    = 1'b1;
    irq_ack = 1'b1;
    cyc();
    tick    = 1'b0;
    irq_ack = 1'b0;
    n_checks++;
    if ({expire, irq, overrun} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL ack_vs_expiry: got e=%b irq=%b ovr=%b expected 1 1 0", expire, irq, overrun);
    end
  endtask

  task automatic test_prescale();
    tick_no = 0;
`ifdef INTERVAL_TIMER_PRESCALE_EN
    exp_q.push_back(8);
`else
    exp_q.push_back(2);
`endif
    do_ack();
    do_load(16'd2);
    do_start(1'b0, 8'd3);
    run_ticks(9);
    n_checks++;
    if ((exp_q.size() != 0) || (irq !== 1'b1)) begin
      n_fail++;
      $display("[TB] FAIL prescale: got pending=%0d irq=%b expected 0 1", exp_q.size(), irq);
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(16'd5);
    do_start(1'b1, 8'd0);
    tick_no = 0;
    run_ticks(2);
    #2;
    arst_n = 1'b0;
    #1;
    n_checks++;
    if ({count, busy, expire, irq, overrun, load_ready} !== {16'h0, 5'b00001}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run: got cnt=%0h b=%b e=%b i=%b o=%b lr=%b expected 0 0 0 0 0 1",
               count, busy, expire, irq, overrun, load_ready);
    end
    cyc();
    arst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_overrun();
    test_stop_at_expiry();
    test_load_in_run();
    test_ack_vs_expiry();
    test_prescale();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
